// File: rtl/zx_vram_arbiter.sv
// zx_vram_arbiter
// Shares the single-port ZX screen RAM (offsets 0x0000-0x1AFF) between
// Z80 bus-snoop writes and the VGA fetch port. Z80 writes to 0x4000-0x5AFF
// are synchronised, queued in a small FIFO and issued in RAM cycles that
// video does not claim.
//
// Optional build macro: ZX_VRAM_STARVE_GUARD_EN
//   When defined, a pending write that has been denied for STARVE_LIMIT
//   cycles takes the next RAM slot even if video is requesting.
//   When undefined, video always wins.
//
// RAM read model: ram_rdata is valid in the cycle the RAM sees ram_addr.
// Because ram_addr is itself registered, that gives the 1-cycle read.

module zx_vram_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [15:0]                  A,
    input  logic [7:0]                   D,
    input  logic                         WR,
    input  logic                         MREQ,
    input  logic                         vid_req,
    input  logic [12:0]                  vid_addr,
    output logic                         vid_gnt,
    output logic                         vid_valid,
    output logic [7:0]                   vid_data,
    output logic [12:0]                  ram_addr,
    output logic                         ram_we,
    output logic [7:0]                   ram_wdata,
    input  logic [7:0]                   ram_rdata,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 21;

    // State table
    //   state  | meaning
    //   IDLE   | write queue empty
    //   BUSY   | at least one queued write awaiting a RAM slot
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 1");
    end

    logic [15:0]   a_m, a_s;
    logic [7:0]    d_m, d_s;
    logic          wr_m, wr_s, wr_d;
    logic          mreq_m, mreq_s;

    logic          wr_fall;
    logic          in_range;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic          full;
    logic          pending;
    logic          force_wr;

    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [EW-1:0] head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] count, count_nxt;
    logic [0:0]    state, state_nxt;

    logic          rd_pend;

    // Two-flop synchronisers, identical depth for every bus signal so they
    // stay cycle-aligned; wr_d is the one-cycle history for edge detection.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            a_m    <= '0;
            a_s    <= '0;
            d_m    <= '0;
            d_s    <= '0;
            wr_m   <= 1'b1;
            wr_s   <= 1'b1;
            wr_d   <= 1'b1;
            mreq_m <= 1'b1;
            mreq_s <= 1'b1;
        end else begin
            a_m    <= A;
            a_s    <= a_m;
            d_m    <= D;
            d_s    <= d_m;
            wr_m   <= WR;
            wr_s   <= wr_m;
            wr_d   <= wr_s;
            mreq_m <= MREQ;
            mreq_s <= mreq_m;
        end
    end

    // Screen window 0x4000-0x5AFF: bits 15:13 are 3'b010 throughout, so the
    // RAM offset is simply the low 13 address bits.
    always_comb begin
        wr_fall  = wr_d & ~wr_s & ~mreq_s;
        in_range = (a_s >= 16'h4000) && (a_s <= 16'h5AFF);
        push     = wr_fall & in_range;
    end

    assign pending = (state == S_BUSY);
    assign full    = (count == LW'(FIFO_DEPTH));
    assign head    = fifo_mem[rd_ptr];

`ifdef ZX_VRAM_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt;

    assign force_wr = pending && (starve_cnt == SW'(STARVE_LIMIT));

    // Counts cycles a queued write has waited; any issued write restarts it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            starve_cnt <= '0;
        end else if (pop || !pending) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign force_wr = 1'b0;
`endif

    // Priority: forced write, then video, then queued write.
    always_comb begin
        vid_gnt = vid_req & ~force_wr;
        pop     = pending & (force_wr | ~vid_req);
        push_ok = push & (~full | pop);
    end

    always_comb begin
        count_nxt = count;
        unique case ({push_ok, pop})
            2'b10:   count_nxt = count + LW'(1);
            2'b01:   count_nxt = count - LW'(1);
            default: count_nxt = count;
        endcase
        state_nxt = (count_nxt != '0) ? S_BUSY : S_IDLE;
    end

    // Queue storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= {a_s[12:0], d_s};
        end
    end

    // Queue pointers, occupancy, state and the sticky drop flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            state    <= S_IDLE;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            state <= state_nxt;
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    assign fifo_level = count;

    // RAM port: one access per cycle, address held when the slot is unused.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
        end else if (pop) begin
            ram_addr  <= head[EW-1:8];
            ram_wdata <= head[7:0];
            ram_we    <= 1'b1;
        end else if (vid_gnt) begin
            ram_addr  <= vid_addr;
            ram_we    <= 1'b0;
        end else begin
            ram_we    <= 1'b0;
        end
    end

    // Read return: grant in n, address in n+1, registered byte in n+2.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_pend   <= 1'b0;
            vid_valid <= 1'b0;
            vid_data  <= '0;
        end else begin
            rd_pend   <= vid_gnt;
            vid_valid <= rd_pend;
            if (rd_pend) begin
                vid_data <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_zx_vram_arbiter.sv
// Directed bench for zx_vram_arbiter: table of Z80 write vectors plus
// hand-written sequences for overflow, read latency, reset and (when
// ZX_VRAM_STARVE_GUARD_EN is defined) the forced write slot.

module tb_zx_vram_arbiter;

    logic        clk = 1'b0;
    logic        RESET;
    logic [15:0] A;
    logic [7:0]  D;
    logic        WR;
    logic        MREQ;
    logic        vid_req;
    logic [12:0] vid_addr;
    logic        vid_gnt;
    logic        vid_valid;
    logic [7:0]  vid_data;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [2:0]  fifo_level;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    logic [7:0]  mem [8192];
    logic [20:0] wq [$];

    zx_vram_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
        .CLK(clk), .RESET(RESET), .A(A), .D(D), .WR(WR), .MREQ(MREQ),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .vid_valid(vid_valid), .vid_data(vid_data), .ram_addr(ram_addr),
        .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .fifo_level(fifo_level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Screen RAM model: synchronous write, read data follows ram_addr.
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
    assign ram_rdata = mem[ram_addr];

    // Record every issued write as {offset, data}.
    always @(negedge clk) if (ram_we) wq.push_back({ram_addr, ram_wdata});

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        mreq;
        int          low;
        int          exp_n;
        logic [12:0] exp_addr;
        logic [7:0]  exp_data;
    } wvec_t;

    wvec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_pulse(input logic [15:0] a, input logic [7:0] d, input logic mreq, input int low);
        A = a; D = d; MREQ = mreq; WR = 1'b1;
        repeat (3) cyc();
        WR = 1'b0;
        repeat (low) cyc();
        WR = 1'b1;
        repeat (3) cyc();
        MREQ = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;

        vecs[0] = '{16'h4000, 8'hA5, 1'b0, 3, 1, 13'h0000, 8'hA5};
        vecs[1] = '{16'h3FFF, 8'h11, 1'b0, 2, 0, 13'h0000, 8'h00};
        vecs[2] = '{16'h5B00, 8'h22, 1'b0, 2, 0, 13'h0000, 8'h00};
        vecs[3] = '{16'h4000, 8'h33, 1'b1, 2, 0, 13'h0000, 8'h00};
        vecs[4] = '{16'h5AFF, 8'h3C, 1'b0, 2, 1, 13'h1AFF, 8'h3C};
        vecs[5] = '{16'h5800, 8'h47, 1'b0, 1, 1, 13'h1800, 8'h47};
        vecs[6] = '{16'h4001, 8'h00, 1'b0, 6, 1, 13'h0001, 8'h00};

        RESET = 1'b1; A = '0; D = '0; WR = 1'b1; MREQ = 1'b1;
        vid_req = 1'b0; vid_addr = '0;
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_vid_valid", 32'(vid_valid), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        cyc();
        RESET = 1'b0;
        repeat (2) cyc();

        // Write-detect table
        for (int i = 0; i < 7; i++) begin
            wq.delete();
            wr_pulse(vecs[i].a, vecs[i].d, vecs[i].mreq, vecs[i].low);
            repeat (8) cyc();
            @(negedge clk);
            chk($sformatf("vec%0d_nwrites", i), 32'(wq.size()), 32'(vecs[i].exp_n));
            if (vecs[i].exp_n != 0 && wq.size() != 0) begin
                chk($sformatf("vec%0d_addr", i), 32'(wq[0][20:8]), 32'(vecs[i].exp_addr));
                chk($sformatf("vec%0d_data", i), 32'(wq[0][7:0]), 32'(vecs[i].exp_data));
            end
            chk($sformatf("vec%0d_level", i), 32'(fifo_level), 0);
        end
        chk("no_overflow_yet", 32'(overflow), 0);

        // Read latency: request in n, byte valid in n+2
        cyc();
        vid_addr = 13'h1800; vid_req = 1'b1;
        @(negedge clk);
        chk("rd_gnt", 32'(vid_gnt), 1);
        cyc();
        vid_req = 1'b0;
        @(negedge clk);
        chk("rd_n1_valid", 32'(vid_valid), 0);
        chk("rd_n1_addr", 32'(ram_addr), 32'h1800);
        chk("rd_n1_we", 32'(ram_we), 0);
        cyc();
        @(negedge clk);
        chk("rd_n2_valid", 32'(vid_valid), 1);
        chk("rd_n2_data", 32'(vid_data), 32'h47);
        cyc();
        @(negedge clk);
        chk("rd_n3_valid", 32'(vid_valid), 0);

        // Back-to-back reads stream one byte per cycle
        cyc();
        vid_addr = 13'h1AFF; vid_req = 1'b1;
        cyc();
        vid_addr = 13'h0000;
        cyc();
        vid_req = 1'b0;
        @(negedge clk);
        chk("stream0_valid", 32'(vid_valid), 1);
        chk("stream0_data", 32'(vid_data), 32'h3C);
        cyc();
        @(negedge clk);
        chk("stream1_valid", 32'(vid_valid), 1);
        chk("stream1_data", 32'(vid_data), 32'hA5);
        repeat (2) cyc();

`ifndef ZX_VRAM_STARVE_GUARD_EN
        // Overflow: six writes while video holds the RAM
        wq.delete();
        vid_addr = 13'h0005; vid_req = 1'b1;
        for (int i = 0; i < 6; i++) wr_pulse(16'h4010 + 16'(i), 8'h10 + 8'(i), 1'b0, 2);
        @(negedge clk);
        chk("ovf_level", 32'(fifo_level), 4);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_no_writes", 32'(wq.size()), 0);
        chk("ovf_gnt", 32'(vid_gnt), 1);
        cyc();
        vid_req = 1'b0;
        repeat (8) cyc();
        @(negedge clk);
        chk("drain_count", 32'(wq.size()), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < wq.size()) begin
                chk($sformatf("drain%0d_addr", i), 32'(wq[i][20:8]), 32'h10 + 32'(i));
                chk($sformatf("drain%0d_data", i), 32'(wq[i][7:0]), 32'h10 + 32'(i));
            end
        end
        chk("drain_level", 32'(fifo_level), 0);
        chk("ovf_sticky", 32'(overflow), 1);

        // Reset with three queued writes and reads in flight
        cyc();
        vid_addr = 13'h0001; vid_req = 1'b1;
        for (int i = 0; i < 3; i++) wr_pulse(16'h4100 + 16'(i), 8'hC0 + 8'(i), 1'b0, 1);
        @(negedge clk);
        chk("pre_rst_level", 32'(fifo_level), 3);
        chk("pre_rst_overflow", 32'(overflow), 1);
        cyc();
        A = 16'h4000; MREQ = 1'b0; WR = 1'b1;
        RESET = 1'b1; vid_req = 1'b0;
        cyc();
        RESET = 1'b0;
        wq.delete();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d_level", k), 32'(fifo_level), 0);
            chk($sformatf("post_rst%0d_overflow", k), 32'(overflow), 0);
            chk($sformatf("post_rst%0d_we", k), 32'(ram_we), 0);
            chk($sformatf("post_rst%0d_valid", k), 32'(vid_valid), 0);
            cyc();
        end
        chk("post_rst_writes", 32'(wq.size()), 0);
        MREQ = 1'b1;
        repeat (2) cyc();
`else
        // Forced write slot after STARVE_LIMIT denied cycles
        begin
            int  ndeny;
            bit  found;
            wq.delete();
            vid_addr = 13'h0000; vid_req = 1'b1;
            A = 16'h4020; D = 8'h5A; MREQ = 1'b0; WR = 1'b1;
            repeat (3) cyc();
            WR = 1'b0;
            found = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (fifo_level != 0) begin
                    found = 1'b1;
                    break;
                end
            end
            chk("starve_queued", 32'(found), 1);
            ndeny = 0;
            found = 1'b0;
            for (int k = 0; k < 40; k++) begin
                if (vid_gnt == 1'b0) begin
                    found = 1'b1;
                    break;
                end
                ndeny++;
                @(negedge clk);
            end
            chk("starve_gnt_drop", 32'(found), 1);
            chk("starve_denied_cycles", 32'(ndeny), 8);
            chk("starve_level_at_force", 32'(fifo_level), 1);
            @(negedge clk);
            chk("starve_we", 32'(ram_we), 1);
            chk("starve_addr", 32'(ram_addr), 32'h0020);
            chk("starve_data", 32'(ram_wdata), 32'h5A);
            chk("starve_gnt_back", 32'(vid_gnt), 1);
            chk("starve_level_after", 32'(fifo_level), 0);
            cyc();
            WR = 1'b1; MREQ = 1'b1; vid_req = 1'b0;
            repeat (4) cyc();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
